// File: rtl/wb_retire_trace.sv
// Writeback retire stage: drives the regfile write port and queues committed
// GPR writes into a small FIFO feeding the debug trace port (1-cycle latency).
module wb_retire_trace #(
  parameter int DEPTH       = 4,
  parameter int FILTER_ZERO = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       WB_Valid_i,
  input  logic [31:0]                WB_PC_i,
  input  logic [4:0]                 WB_Dst_i,
  input  logic [31:0]                WB_Result_i,
  input  logic                       WB_RFWr_i,
  input  logic                       Trace_Ready_i,
  output logic                       RF_Wr_o,
  output logic [4:0]                 RF_Dst_o,
  output logic [31:0]                RF_Data_o,
  output logic                       WB_TraceStall_o,
  output logic [31:0]                debug_wb_pc_o,
  output logic [3:0]                 debug_wb_rf_wen_o,
  output logic [4:0]                 debug_wb_rf_wnum_o,
  output logic [31:0]                debug_wb_rf_wdata_o,
  output logic [$clog2(DEPTH):0]     Trace_Count_o,
  output logic                       Trace_Overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            real_wr;
  logic            qualifies;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          new_entry;
  entry_t          head;

  assign real_wr   = WB_RFWr_i & (WB_Dst_i != 5'd0);
  assign qualifies = (FILTER_ZERO != 0) ? real_wr : 1'b1;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

  // Stall is a function of occupancy and the sink only, so it cannot form a
  // combinational loop with the upstream valid.
  assign WB_TraceStall_o = full & ~Trace_Ready_i;

  assign push = WB_Valid_i & ~WB_TraceStall_o & qualifies;
  assign pop  = ~empty & Trace_Ready_i;

  assign RF_Wr_o   = WB_Valid_i & ~WB_TraceStall_o & real_wr;
  assign RF_Dst_o  = WB_Dst_i;
  assign RF_Data_o = WB_Result_i;

  always_comb begin
    new_entry      = '0;
    new_entry.pc   = WB_PC_i;
    new_entry.wen  = real_wr;
    new_entry.dst  = WB_Dst_i;
    new_entry.data = WB_Result_i;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q];
  end

  assign debug_wb_pc_o       = head.pc;
  assign debug_wb_rf_wen_o   = {4{head.wen}};
  assign debug_wb_rf_wnum_o  = head.dst;
  assign debug_wb_rf_wdata_o = head.data;
  assign Trace_Count_o       = count_q;
  assign Trace_Overflow_o    = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // Raw valid: upstream drove a qualifying retire straight through the stall.
    if (WB_Valid_i && qualifies && full && !Trace_Ready_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) mem_q[wr_ptr_q] <= new_entry;
  end

endmodule
